// File: rtl/div3_word_driver.sv
// Word-to-serial feeder for the divisible-by-3 checker: accepts a word, shifts it
// MSB-first into the checker, samples the verdict and returns it with the word.
module div3_word_driver #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             chk_resetn,
  output logic             chk_din,
  input  logic             chk_dout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_div3,
  output logic [WIDTH-1:0] res_data
);

  typedef enum logic [1:0] {IDLE, SHIFT, SAMPLE, RESP} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  // Registered copy of resetn; keeps in_ready low while reset is sampled
  // without a combinational path from resetn to the outputs.
  logic             run;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      run   <= 1'b0;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = SHIFT;
      SHIFT:   if (cnt == LAST) state_nx = SAMPLE;
      SAMPLE:  state_nx = RESP;
      RESP:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt      <= '0;
      shreg    <= '0;
      res_div3 <= 1'b0;
      res_data <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          shreg    <= in_data;
          res_data <= in_data;
          cnt      <= '0;
        end
        SHIFT: begin
          shreg <= shreg << 1;
          cnt   <= cnt + 1'b1;
        end
        // Checker state now covers all bits; it is cleared on this same edge.
        SAMPLE:  res_div3 <= chk_dout;
        default: ;
      endcase
    end
  end

  // Checker is held in reset in every non-SHIFT cycle, so each word starts clean.
  assign in_ready   = (state == IDLE) && run;
  assign chk_resetn = (state == SHIFT);
  assign chk_din    = (state == SHIFT) && shreg[WIDTH-1];
  assign res_valid  = (state == RESP);

endmodule

// File: tb/tb_div3_word_driver.sv
// Directed bench for div3_word_driver at WIDTH 8, 4 and 1, each driving a
// behavioural serial mod-3 checker.
module tb_div3_word_driver;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] iv, ir, crn, cdin, cdout, rv, rr, rdiv;
  logic [7:0] d8, rd8;
  logic [3:0] d4, rd4;
  logic [0:0] d1, rd1;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  div3_word_driver #(.WIDTH(8)) u8 (
    .clk(clk), .resetn(resetn), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(d8),
    .chk_resetn(crn[0]), .chk_din(cdin[0]), .chk_dout(cdout[0]),
    .res_valid(rv[0]), .res_ready(rr[0]), .res_div3(rdiv[0]), .res_data(rd8));
  div3_word_driver #(.WIDTH(4)) u4 (
    .clk(clk), .resetn(resetn), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(d4),
    .chk_resetn(crn[1]), .chk_din(cdin[1]), .chk_dout(cdout[1]),
    .res_valid(rv[1]), .res_ready(rr[1]), .res_div3(rdiv[1]), .res_data(rd4));
  div3_word_driver #(.WIDTH(1)) u1 (
    .clk(clk), .resetn(resetn), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(d1),
    .chk_resetn(crn[2]), .chk_din(cdin[2]), .chk_dout(cdout[2]),
    .res_valid(rv[2]), .res_ready(rr[2]), .res_div3(rdiv[2]), .res_data(rd1));

  // Serial checker model: remainder of the MSB-first value seen since reset.
  for (genvar g = 0; g < 3; g++) begin : g_chk
    logic [1:0] rem = 2'd0;
    always @(posedge clk) begin
      if (!crn[g]) rem <= 2'd0;
      else         rem <= 2'((int'(rem) * 2 + int'(cdin[g])) % 3);
    end
    assign cdout[g] = (rem == 2'd0);
  end

  typedef struct {
    logic [7:0] d;
    logic       exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] echo_of(input int k);
    case (k)
      0:       return rd8;
      1:       return {4'h0, rd4};
      default: return {7'h0, rd1};
    endcase
  endfunction

  task automatic wait_ready(input int k);
    int n = 0;
    while (!ir[k] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("in_ready_timeout", 32'(ir[k]), 32'd1);
  endtask

  // Send one word to instance k and wait for its response (res_ready held high).
  task automatic do_word(input int k, input logic [7:0] d,
                         output logic dv, output logic [7:0] echo, output int lat);
    @(negedge clk);
    d8 = d; d4 = d[3:0]; d1 = d[0];
    iv[k] = 1'b1; rr[k] = 1'b1;
    wait_ready(k);
    @(negedge clk);
    iv[k] = 1'b0;
    lat = 1;
    while (!rv[k] && lat < 60) begin @(negedge clk); lat++; end
    dv   = rv[k] ? rdiv[k] : 1'bx;
    echo = echo_of(k);
  endtask

  initial begin
    logic       dv;
    logic [7:0] echo;
    int         lat, seen, n;
    logic [9:0] obs_din, obs_rn, obs_rv;

    vecs[0]  = '{8'h00, 1'b1};  vecs[1]  = '{8'hFF, 1'b1};
    vecs[2]  = '{8'h07, 1'b0};  vecs[3]  = '{8'h80, 1'b0};
    vecs[4]  = '{8'h0C, 1'b1};  vecs[5]  = '{8'h09, 1'b1};
    vecs[6]  = '{8'h05, 1'b0};  vecs[7]  = '{8'h06, 1'b1};
    vecs[8]  = '{8'h03, 1'b1};  vecs[9]  = '{8'h01, 1'b0};
    vecs[10] = '{8'hAA, 1'b0};  vecs[11] = '{8'h99, 1'b1};

    resetn = 1'b0; iv = '0; rr = '0; d8 = '0; d4 = '0; d1 = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_in_ready%0d", k),  32'(ir[k]),   32'd0);
      check($sformatf("rst_res_valid%0d", k), 32'(rv[k]),   32'd0);
      check($sformatf("rst_chk_rn%0d", k),    32'(crn[k]),  32'd0);
      check($sformatf("rst_chk_din%0d", k),   32'(cdin[k]), 32'd0);
    end
    check("rst_res_div3", 32'(rdiv[0]), 32'd0);
    check("rst_res_data", 32'(rd8), 32'd0);
    resetn = 1'b1;

    // Cycle-accurate trace of 0x0C on the 8-bit instance.
    wait_ready(0);
    d8 = 8'h0C; iv[0] = 1'b1; rr[0] = 1'b1;
    obs_din = '0; obs_rn = '0; obs_rv = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) iv[0] = 1'b0;
      obs_din[c-1] = cdin[0];
      obs_rn[c-1]  = crn[0];
      obs_rv[c-1]  = rv[0];
    end
    check("trace_chk_din", 32'(obs_din), 32'h030);
    check("trace_chk_rn",  32'(obs_rn),  32'h0FF);
    check("trace_res_valid", 32'(obs_rv), 32'h200);
    check("trace_div3", 32'(rdiv[0]), 32'd1);
    check("trace_data", 32'(rd8), 32'h0C);

    for (int i = 0; i < 12; i++) begin
      do_word(0, vecs[i].d, dv, echo, lat);
      check($sformatf("vec%0d_div3", i), 32'(dv),   32'(vecs[i].exp));
      check($sformatf("vec%0d_echo", i), 32'(echo), 32'(vecs[i].d));
      check($sformatf("vec%0d_lat", i),  32'(lat),  32'd10);
    end

    // Backpressure: hold the 0x09 verdict for 5 cycles.
    @(negedge clk);
    rr[0] = 1'b0; d8 = 8'h09; iv[0] = 1'b1;
    wait_ready(0);
    @(negedge clk); iv[0] = 1'b0;
    n = 0;
    while (!rv[0] && n < 60) begin @(negedge clk); n++; end
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(rv[0]),   32'd1);
      check("bp_div3",  32'(rdiv[0]), 32'd1);
      check("bp_data",  32'(rd8),     32'h09);
      check("bp_ready", 32'(ir[0]),   32'd0);
      @(negedge clk);
    end
    rr[0] = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(rv[0]), 32'd0);
    check("bp_release_idle",  32'(ir[0]), 32'd1);

    // Back-to-back 0x05 then 0x06 with in_valid held high.
    d8 = 8'h05; iv[0] = 1'b1; rr[0] = 1'b1;
    wait_ready(0);
    @(negedge clk); d8 = 8'h06;
    n = 0;
    while (!rv[0] && n < 60) begin @(negedge clk); n++; end
    check("b2b_first_div3", 32'(rdiv[0]), 32'd0);
    check("b2b_first_data", 32'(rd8), 32'h05);
    @(negedge clk);
    check("b2b_accept_ready", 32'(ir[0]), 32'd1);
    check("b2b_clear", 32'(crn[0]), 32'd0);
    @(negedge clk); iv[0] = 1'b0;
    check("b2b_second_shift", 32'(crn[0]), 32'd1);
    n = 0;
    while (!rv[0] && n < 60) begin @(negedge clk); n++; end
    check("b2b_second_div3", 32'(rdiv[0]), 32'd1);
    check("b2b_second_data", 32'(rd8), 32'h06);

    // Reset pulse in the 4th SHIFT cycle of 0xFF.
    @(negedge clk);
    d8 = 8'hFF; iv[0] = 1'b1;
    wait_ready(0);
    @(negedge clk); iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("midrst_chk_rn", 32'(crn[0]), 32'd0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (rv[0]) seen++;
      @(negedge clk);
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    do_word(0, 8'h03, dv, echo, lat);
    check("midrst_next_div3", 32'(dv), 32'd1);
    check("midrst_next_echo", 32'(echo), 32'h03);

    for (int v = 0; v < 16; v++) begin
      do_word(1, 8'(v), dv, echo, lat);
      check($sformatf("w4_%0d_div3", v), 32'(dv), 32'((v % 3) == 0));
      check($sformatf("w4_%0d_echo", v), 32'(echo), 32'(v));
    end
    check("w4_lat", 32'(lat), 32'd6);
    for (int v = 0; v < 2; v++) begin
      do_word(2, 8'(v), dv, echo, lat);
      check($sformatf("w1_%0d_div3", v), 32'(dv), 32'((v % 3) == 0));
      check($sformatf("w1_%0d_echo", v), 32'(echo), 32'(v));
      check($sformatf("w1_%0d_lat", v), 32'(lat), 32'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div3_word_driver.md
Name: div3_word_driver

Overview:
- Upstream feeder for the serial divisible-by-3 checker.
- Accepts a parallel WIDTH-bit word on a valid/ready handshake and shifts it into the checker MSB-first, one bit per cycle, on chk_din.
- Drives the checker's synchronous active-low reset (chk_resetn) to clear its remainder between words.
- Samples the checker's dout after the last bit and returns the verdict, with the word echoed, on a valid/ready response channel.

Parameters:
- WIDTH, 8, bits per input word (legal range WIDTH >= 1).
- CNT_W, $clog2(WIDTH+1), shift-counter width (derived; do not override).

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous reset, active-low
- in_valid  input  1  word available
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  word; bit WIDTH-1 is shifted first
- chk_resetn  output  1  to checker resetn (active-low, synchronous)
- chk_din  output  1  to checker din
- chk_dout  input  1  from checker dout (1 = cumulative value divisible by 3)
- res_valid  output  1  verdict available
- res_ready  input  1  consumer accepts verdict
- res_div3  output  1  1 if the echoed word mod 3 == 0
- res_data  output  WIDTH  echo of the accepted word

Behaviour:
- Reset: clock is clk; reset is resetn, synchronous, active-low.
  - State goes to IDLE, counter to 0, shift register to 0, res_div3 to 0, res_data to 0.
  - While resetn is low: in_ready=0, res_valid=0, chk_resetn=0, chk_din=0.
- All outputs decode from registered state only. There is no combinational path from any input to any output.
- FSM states: IDLE, SHIFT, SAMPLE, RESP.
- IDLE:
  - in_ready=1, chk_resetn=0 (checker held at its start state), chk_din=0.
  - On in_valid & in_ready: shreg<=in_data, res_data<=in_data, cnt<=0, go to SHIFT.
- SHIFT:
  - chk_resetn=1, chk_din=shreg[WIDTH-1].
  - Each cycle: shreg<=shreg<<1, cnt<=cnt+1.
  - When cnt==WIDTH-1, go to SAMPLE. SHIFT lasts exactly WIDTH cycles.
- SAMPLE (one cycle):
  - chk_resetn=0, chk_din=0.
  - chk_dout now reflects all WIDTH bits. Register res_div3<=chk_dout at the end of this cycle.
  - The checker returns to its start state on the same edge.
  - Go to RESP.
- RESP:
  - res_valid=1, chk_resetn=0, in_ready=0.
  - res_div3 and res_data stay stable until res_valid & res_ready.
  - On handshake, go to IDLE.
- Latency: accept in cycle 0 -> SHIFT in cycles 1..WIDTH -> SAMPLE in cycle WIDTH+1 -> res_valid first high in cycle WIDTH+2.
- Throughput: at most one word per WIDTH+3 cycles. in_ready is never high in the same cycle as res_valid.
- chk_resetn is low in every non-SHIFT cycle. This guarantees the checker is cleared before every word's first bit, with no extra clear cycle.
- Leading zeros are shifted like any other bit. Word 0 yields res_div3=1.
- Reset mid-operation (any state): abort the current word and discard its verdict. The next cycle with resetn high is IDLE, and no partial res_valid appears.
- in_valid while the block is not in IDLE: ignored; the upstream holds the word per valid/ready rules.
- res_ready asserted outside RESP: no effect.
- WIDTH=1: SHIFT lasts 1 cycle; the verdict is 1 for a 0 input and 0 for a 1 input.

Test Plan:
- WIDTH=8, in_data=0x0C, res_ready=1:
  - chk_din over cycles 1-8 = 0,0,0,0,1,1,0,0.
  - chk_resetn is 1 in cycles 1-8 only.
  - res_valid is high in cycle 10 with res_div3=1 and res_data=0x0C.
- Values with the real checker attached:
  - 0x00 -> res_div3=1
  - 0xFF -> res_div3=1 (255)
  - 0x07 -> res_div3=0 (7 mod 3 = 1)
  - 0x80 -> res_div3=0 (128 mod 3 = 2)
- Backpressure: 0x09 accepted, res_ready held low for 5 cycles.
  - res_valid, res_div3=1 and res_data=0x09 are held stable.
  - in_ready stays 0.
  - After res_ready=1, IDLE follows in the next cycle.
- Back-to-back: in_valid held high with 0x05 then 0x06.
  - Second accept occurs exactly one cycle after the first response handshake.
  - Verdicts are 0 then 1; checker clear is confirmed between words.
- Reset mid-word: resetn pulled low for 1 cycle at the 4th SHIFT cycle of 0xFF.
  - No res_valid is produced.
  - A following 0x03 gives res_div3=1.
- Exhaustive: for WIDTH=4 and WIDTH=1, apply every input value; res_div3 must equal (in_data % 3 == 0).
